// File: rtl/if_id_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : if_id_queue
// Brief    : IF/ID instruction queue with RV32I decoder, decode register,
//            sticky exception capture and register file. Optional write-back
//            bypass on the operand reads is enabled by IF_ID_QUEUE_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_queue #(
    parameter logic [31:0] RESET = 32'h0000_0000,
    parameter int          DEPTH = 4,
    parameter int          NREGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_inst,
    input  logic [31:0] fetch_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_imm,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rs2,
    output logic [4:0]  dec_rd,
    output logic [13:0] dec_ctrl,
    output logic [31:0] dec_rdata1,
    output logic [31:0] dec_rdata2,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        exception,
    output logic [31:0] exc_pc
);

    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = PW + 1;
    localparam int          RW      = $clog2(NREGS);
    localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
    localparam logic [5:0]  C_NREGS = 6'(NREGS);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ARITHI = 7'b0010011;
    localparam logic [6:0] OP_ARITHR = 7'b0110011;

    logic [31:0]   q_inst_q [DEPTH];
    logic [31:0]   q_pc_q   [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          dec_valid_q;
    logic [31:0]   dec_pc_q, dec_imm_q;
    logic [4:0]    dec_rs1_q, dec_rs2_q, dec_rd_q;
    logic [13:0]   dec_ctrl_q;
    logic          exception_q;
    logic [31:0]   exc_pc_q;
    logic [31:0]   regs_q [NREGS];

    logic          w_push, w_pop;
    logic [31:0]   w_hinst, w_hpc;
    logic [31:0]   w_imm;
    logic [13:0]   w_ctrl;
    logic          w_illegal;
    logic [31:0]   w_rdata1, w_rdata2;

    assign fetch_ready = (count_q != C_FULL);
    assign w_push      = fetch_valid && fetch_ready && !flush;
    assign w_pop       = (count_q != '0) && (!dec_valid_q || dec_ready) && !flush;
    assign w_hinst     = q_inst_q[rd_ptr_q];
    assign w_hpc       = q_pc_q[rd_ptr_q];

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (w_push && !w_pop)      count_d = count_q + 1'b1;
        else if (!w_push && w_pop) count_d = count_q - 1'b1;
    end

    // Decode of the queue head; the result is captured only when it pops.
    always_comb begin
        logic [6:0] op;
        logic [2:0] f3;
        logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
        logic is_load, is_store, is_arithi, is_arithr;
        logic use_rs1, use_rs2, use_rd, bad_reg;
        op        = w_hinst[6:0];
        f3        = w_hinst[14:12];
        is_lui    = (op == OP_LUI);
        is_auipc  = (op == OP_AUIPC);
        is_jal    = (op == OP_JAL);
        is_jalr   = (op == OP_JALR);
        is_branch = (op == OP_BRANCH);
        is_load   = (op == OP_LOAD);
        is_store  = (op == OP_STORE);
        is_arithi = (op == OP_ARITHI);
        is_arithr = (op == OP_ARITHR);
        use_rs1   = is_jalr | is_branch | is_load | is_store | is_arithi | is_arithr;
        use_rs2   = is_branch | is_store | is_arithr;
        use_rd    = is_lui | is_auipc | is_jal | is_jalr | is_load | is_arithi | is_arithr;
        bad_reg   = (NREGS == 16) && ((use_rs1 && w_hinst[19]) ||
                                      (use_rs2 && w_hinst[24]) ||
                                      (use_rd  && w_hinst[11]));
        w_illegal = !(use_rs1 | use_rd | is_store | is_branch) || bad_reg;
        w_imm     = '0;
        w_ctrl    = '0;
        if (w_illegal) begin
            w_ctrl[12] = 1'b1;
        end else begin
            if (is_arithi && (f3 == 3'b001 || f3 == 3'b101))
                w_imm = {27'b0, w_hinst[24:20]};
            else if (is_jalr || is_load || is_arithi)
                w_imm = {{20{w_hinst[31]}}, w_hinst[31:20]};
            else if (is_store)
                w_imm = {{20{w_hinst[31]}}, w_hinst[31:25], w_hinst[11:7]};
            else if (is_branch)
                w_imm = {{19{w_hinst[31]}}, w_hinst[31], w_hinst[7], w_hinst[30:25], w_hinst[11:8], 1'b0};
            else if (is_jal)
                w_imm = {{11{w_hinst[31]}}, w_hinst[31], w_hinst[19:12], w_hinst[20], w_hinst[30:21], 1'b0};
            else if (is_lui || is_auipc)
                w_imm = {w_hinst[31:12], 12'b0};
            w_ctrl[0]    = is_jalr | is_load | is_arithi | is_auipc;
            w_ctrl[1]    = is_arithi | is_arithr;
            w_ctrl[2]    = is_lui;
            w_ctrl[3]    = is_jal;
            w_ctrl[4]    = is_jalr;
            w_ctrl[5]    = is_branch;
            w_ctrl[6]    = is_store;
            w_ctrl[7]    = is_load;
            w_ctrl[8]    = w_hinst[30] && !(is_arithi && f3 == 3'b000);
            w_ctrl[11:9] = f3;
            w_ctrl[13]   = is_auipc;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            q_inst_q[wr_ptr_q] <= fetch_inst;
            q_pc_q[wr_ptr_q]   <= fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dec_valid_q <= 1'b0;
            dec_pc_q    <= RESET;
            dec_imm_q   <= '0;
            dec_rs1_q   <= '0;
            dec_rs2_q   <= '0;
            dec_rd_q    <= '0;
            dec_ctrl_q  <= '0;
            exception_q <= 1'b0;
            exc_pc_q    <= RESET;
        end else if (flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dec_valid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (w_pop) begin
                dec_valid_q <= 1'b1;
                dec_pc_q    <= w_hpc;
                dec_imm_q   <= w_imm;
                dec_rs1_q   <= w_hinst[19:15];
                dec_rs2_q   <= w_hinst[24:20];
                dec_rd_q    <= w_hinst[11:7];
                dec_ctrl_q  <= w_ctrl;
                // Only the first faulting instruction is recorded.
                if (!exception_q && (w_illegal || w_hpc[1:0] != 2'b00)) begin
                    exception_q <= 1'b1;
                    exc_pc_q    <= w_hpc;
                end
            end else if (dec_ready) begin
                dec_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0 && {1'b0, wb_rd} < C_NREGS) begin
            regs_q[wb_rd[RW-1:0]] <= wb_data;
        end
    end

    always_comb begin
        w_rdata1 = ({1'b0, dec_rs1_q} < C_NREGS) ? regs_q[dec_rs1_q[RW-1:0]] : 32'h0;
        w_rdata2 = ({1'b0, dec_rs2_q} < C_NREGS) ? regs_q[dec_rs2_q[RW-1:0]] : 32'h0;
`ifdef IF_ID_QUEUE_WB_BYPASS_EN
        if (wb_en && wb_rd != 5'd0 && wb_rd == dec_rs1_q) w_rdata1 = wb_data;
        if (wb_en && wb_rd != 5'd0 && wb_rd == dec_rs2_q) w_rdata2 = wb_data;
`endif
    end

    assign dec_valid  = dec_valid_q;
    assign dec_pc     = dec_pc_q;
    assign dec_imm    = dec_imm_q;
    assign dec_rs1    = dec_rs1_q;
    assign dec_rs2    = dec_rs2_q;
    assign dec_rd     = dec_rd_q;
    assign dec_ctrl   = dec_ctrl_q;
    assign dec_rdata1 = w_rdata1;
    assign dec_rdata2 = w_rdata2;
    assign exception  = exception_q;
    assign exc_pc     = exc_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_if_id_queue
// Brief    : Scoreboard bench for if_id_queue (default and 16-register builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [13:0] ctrl;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, flush, fetch_valid, dec_ready, wb_en;
    logic [31:0] fetch_inst, fetch_pc, wb_data;
    logic [4:0]  wb_rd;
    logic        fetch_ready, dec_valid, exception;
    logic [31:0] dec_pc, dec_imm, dec_rdata1, dec_rdata2, exc_pc;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [13:0] dec_ctrl;

    logic        f16_valid, d16_ready;
    logic [31:0] f16_inst, f16_pc;
    logic        f16_ready, d16_valid, exc16;
    logic [31:0] d16_pc, d16_imm, d16_rdata1, d16_rdata2, exc16_pc;
    logic [4:0]  d16_rs1, d16_rs2, d16_rd;
    logic [13:0] d16_ctrl;

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t mon_e, mon_a;

    always #5 clk = ~clk;

    if_id_queue #(.RESET(32'h0000_1000), .DEPTH(4), .NREGS(32)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_inst(fetch_inst), .fetch_pc(fetch_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_imm(dec_imm), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rd(dec_rd), .dec_ctrl(dec_ctrl),
        .dec_rdata1(dec_rdata1), .dec_rdata2(dec_rdata2),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .exception(exception), .exc_pc(exc_pc)
    );

    if_id_queue #(.RESET(32'h0), .DEPTH(2), .NREGS(16)) u_dut16 (
        .clk(clk), .reset(reset), .flush(1'b0),
        .fetch_valid(f16_valid), .fetch_ready(f16_ready),
        .fetch_inst(f16_inst), .fetch_pc(f16_pc),
        .dec_valid(d16_valid), .dec_ready(d16_ready),
        .dec_pc(d16_pc), .dec_imm(d16_imm), .dec_rs1(d16_rs1), .dec_rs2(d16_rs2),
        .dec_rd(d16_rd), .dec_ctrl(d16_ctrl),
        .dec_rdata1(d16_rdata1), .dec_rdata2(d16_rdata2),
        .wb_en(1'b0), .wb_rd(5'd0), .wb_data(32'h0),
        .exception(exc16), .exc_pc(exc16_pc)
    );

    // Monitor: every handshake on the decode side retires one expected entry.
    always @(negedge clk) begin
        if (reset && !flush && dec_valid && dec_ready) begin
            vectors++;
            mon_a = '{dec_pc, dec_imm, dec_rs1, dec_rs2, dec_rd, dec_ctrl};
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL dec_unexpected got pc=%h imm=%h ctrl=%h required no output", dec_pc, dec_imm, dec_ctrl);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_a !== mon_e) begin
                    miscompares++;
                    $display("FAIL dec_out got pc=%h imm=%h rs1=%0d rs2=%0d rd=%0d ctrl=%h required pc=%h imm=%h rs1=%0d rs2=%0d rd=%0d ctrl=%h",
                             mon_a.pc, mon_a.imm, mon_a.rs1, mon_a.rs2, mon_a.rd, mon_a.ctrl,
                             mon_e.pc, mon_e.imm, mon_e.rs1, mon_e.rs2, mon_e.rd, mon_e.ctrl);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
        int n;
        n = 0;
        fetch_valid = 1'b1;
        fetch_inst  = inst;
        fetch_pc    = pc;
        @(negedge clk);
        while (!fetch_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!fetch_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout got fetch_ready=0 required 1 (pc=%h)", pc);
            fetch_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            @(posedge clk); #1;
            fetch_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic push16(input logic [31:0] inst, input logic [31:0] pc);
        f16_valid = 1'b1;
        f16_inst  = inst;
        f16_pc    = pc;
        @(posedge clk); #1;
        f16_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b0; flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
        fetch_inst = '0; fetch_pc = '0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        f16_valid = 1'b0; f16_inst = '0; f16_pc = '0; d16_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("rst_dec_pc",    dec_pc,  32'h0000_1000);
        chk("rst_dec_imm",   dec_imm, 32'h0);
        chk("rst_dec_ctrl",  {18'b0, dec_ctrl}, 32'h0);
        chk("rst_exception", {31'b0, exception}, 32'd0);
        chk("rst_exc_pc",    exc_pc,  32'h0000_1000);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_fetch_ready", {31'b0, fetch_ready}, 32'd1);
        @(posedge clk); #1;

        // addi x1,x0,5: one-edge latency, no fall-through
        dec_ready = 1'b1;
        push(32'h00500093, 32'h0, '{32'h0, 32'd5, 5'd0, 5'd5, 5'd1, 14'h0003});
        chk("no_fallthrough", {31'b0, dec_valid}, 32'd0);
        @(posedge clk); #1;
        chk("addi_valid", {31'b0, dec_valid}, 32'd1);
        chk("addi_rd", {27'b0, dec_rd}, 32'd1);
        drain();

        // Fill with decode stalled: 5 accepts, then back-pressure
        dec_ready = 1'b0;
        push(32'h002081B3, 32'h100, '{32'h100, 32'h0,        5'd1, 5'd2,  5'd3,  14'h0002});
        push(32'h407302B3, 32'h104, '{32'h104, 32'h0,        5'd6, 5'd7,  5'd5,  14'h0102});
        push(32'h40325213, 32'h108, '{32'h108, 32'd3,        5'd4, 5'd3,  5'd4,  14'h0B03});
        push(32'h00412403, 32'h10C, '{32'h10C, 32'd4,        5'd2, 5'd4,  5'd8,  14'h0481});
        push(32'h0050A423, 32'h110, '{32'h110, 32'd8,        5'd1, 5'd5,  5'd8,  14'h0440});
        fetch_valid = 1'b1; fetch_inst = 32'h00208463; fetch_pc = 32'h114;
        @(negedge clk);
        chk("full_fetch_ready", {31'b0, fetch_ready}, 32'd0);
        chk("stall_pc_a", dec_pc, 32'h100);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_pc_b", dec_pc, 32'h100);
        chk("stall_ctrl", {18'b0, dec_ctrl}, 32'h0002);
        chk("still_full", {31'b0, fetch_ready}, 32'd0);
        @(posedge clk); #1;
        dec_ready = 1'b1;
        push(32'h00208463, 32'h114, '{32'h114, 32'd8, 5'd1, 5'd2, 5'd8, 14'h0020});
        drain();

        // Flush with three queued entries and a concurrent fetch
        dec_ready = 1'b0;
        push(32'h010000EF, 32'h200, '{32'h200, 32'd16, 5'd0, 5'd16, 5'd1, 14'h0008});
        push(32'h00008067, 32'h204, '{32'h204, 32'd0,  5'd1, 5'd0,  5'd0, 14'h0011});
        push(32'h00412403, 32'h208, '{32'h208, 32'd4,  5'd2, 5'd4,  5'd8, 14'h0481});
        push(32'h00208463, 32'h20C, '{32'h20C, 32'd8,  5'd1, 5'd2,  5'd8, 14'h0020});
        chk("three_queued_ready", {31'b0, fetch_ready}, 32'd1);
        flush = 1'b1; fetch_valid = 1'b1; fetch_inst = 32'h00500093; fetch_pc = 32'h210;
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0; fetch_valid = 1'b0;
        chk("flush_dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("flush_fetch_ready", {31'b0, fetch_ready}, 32'd1);
        dec_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("flush_no_ghost", {31'b0, dec_valid}, 32'd0);
        chk("no_exc_yet", {31'b0, exception}, 32'd0);
        push(32'hFFF10113, 32'h220, '{32'h220, 32'hFFFF_FFFF, 5'd2, 5'd31, 5'd2, 14'h0003});
        drain();

        // Illegal instruction and sticky exception
        push(32'hFFFFFFFF, 32'h40, '{32'h40, 32'h0, 5'd31, 5'd31, 5'd31, 14'h1000});
        push(32'h002081B3, 32'h44, '{32'h44, 32'h0, 5'd1, 5'd2, 5'd3, 14'h0002});
        drain();
        chk("exc_set", {31'b0, exception}, 32'd1);
        chk("exc_pc_first", exc_pc, 32'h40);
        push(32'h00500093, 32'h46, '{32'h46, 32'd5, 5'd0, 5'd5, 5'd1, 14'h0003});
        drain();
        chk("exc_pc_held", exc_pc, 32'h40);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("exc_survives_flush", {31'b0, exception}, 32'd1);

        // Register file write and operand read (addi x1,x3,0 held in decode)
        dec_ready = 1'b0;
        push(32'h00018093, 32'h300, '{32'h300, 32'h0, 5'd3, 5'd0, 5'd1, 14'h0003});
        n = 0;
        while (!dec_valid && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk("rf_dec_valid", {31'b0, dec_valid}, 32'd1);
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        #1;
`ifdef IF_ID_QUEUE_WB_BYPASS_EN
        chk("rf_same_cycle", dec_rdata1, 32'hDEADBEEF);
`else
        chk("rf_same_cycle", dec_rdata1, 32'h0);
`endif
        @(posedge clk); #1;
        wb_en = 1'b0;
        chk("rf_after_write", dec_rdata1, 32'hDEADBEEF);
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1;
        #1;
        chk("rf_x0_same_cycle", dec_rdata2, 32'h0);
        @(posedge clk); #1;
        wb_en = 1'b0;
        chk("rf_x0_after", dec_rdata2, 32'h0);
        dec_ready = 1'b1;
        drain();

        // 16-register build: x17 is illegal
        push16(32'h002081B3, 32'h80);
        chk("r16_legal_valid", {31'b0, d16_valid}, 32'd1);
        chk("r16_legal_ctrl", {18'b0, d16_ctrl}, 32'h0002);
        chk("r16_no_exc", {31'b0, exc16}, 32'd0);
        push16(32'h002088B3, 32'h84);
        chk("r16_illegal_ctrl", {18'b0, d16_ctrl}, 32'h1000);
        chk("r16_exc", {31'b0, exc16}, 32'd1);
        chk("r16_exc_pc", exc16_pc, 32'h84);

        // Asynchronous reset while instructions are in flight
        dec_ready = 1'b0;
        push(32'h00500093, 32'h500, '{32'h500, 32'd5, 5'd0, 5'd5, 5'd1, 14'h0003});
        push(32'h002081B3, 32'h504, '{32'h504, 32'h0, 5'd1, 5'd2, 5'd3, 14'h0002});
        @(negedge clk); #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_valid", {31'b0, dec_valid}, 32'd0);
        chk("async_rst_pc", dec_pc, 32'h0000_1000);
        chk("async_rst_exc", {31'b0, exception}, 32'd0);
        chk("async_rst_exc_pc", exc_pc, 32'h0000_1000);
        @(posedge clk); #1;
        reset = 1'b1;
        dec_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_empty", {31'b0, dec_valid}, 32'd0);
        chk("post_rst_ready", {31'b0, fetch_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
